draw_bg_sprite: RTL and testbench

- Parametrised successor to the team's background drawer.
- Draws the background with:
  - a blanking-aware fill selected by mode: solid, checkerboard or gradient;
  - coloured frame edges of configurable thickness;
  - a 1-bit signature bitmap (logo) that can bounce around the visible area, moving once per frame.
- Sits directly after the VGA timing generator and ahead of the rectangle/char drawers.
- Registered pipeline with a fixed 2-cycle latency on all timing signals.

---
 rtl/draw_bg_sprite_pkg.sv | 47 ++++
 rtl/draw_bg_sprite_logo_mover.sv | 66 ++++++
 rtl/draw_bg_sprite.sv | 172 +++++++++++++++++
 tb/tb_draw_bg_sprite.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_bg_sprite_pkg.sv
// Shared types and constants for the background/sprite drawer: edge classes,
// fill modes, fixed edge colours and the 1-bit signature bitmap.
package draw_bg_sprite_pkg;

    localparam int LOGO_W_DEF = 16;
    localparam int LOGO_H_DEF = 8;

    typedef enum logic {
        DIR_DEC = 1'b0,
        DIR_INC = 1'b1
    } dir_e;

    typedef enum logic [2:0] {
        EDGE_NONE,
        EDGE_TOP,
        EDGE_BOTTOM,
        EDGE_LEFT,
        EDGE_RIGHT
    } edge_e;

    typedef enum logic [1:0] {
        MODE_SOLID    = 2'd0,
        MODE_CHECKER  = 2'd1,
        MODE_GRADIENT = 2'd2,
        MODE_HIDDEN   = 2'd3
    } mode_e;

    localparam logic [11:0] RGB_BLANK      = 12'h000;
    localparam logic [11:0] RGB_TOP        = 12'hff0;
    localparam logic [11:0] RGB_BOTTOM     = 12'hf00;
    localparam logic [11:0] RGB_LEFT       = 12'h0f0;
    localparam logic [11:0] RGB_RIGHT      = 12'h00f;
    localparam logic [11:0] RGB_CHECK_DARK = 12'h444;

    // Row index first, then column; row 0 is the last element of the concatenation.
    localparam logic [LOGO_H_DEF-1:0][LOGO_W_DEF-1:0] LOGO_ROM = {
        16'hFFFF,
        16'h8001,
        16'hB3CD,
        16'hA5A1,
        16'hA521,
        16'hB3CD,
        16'h8001,
        16'hFFFF
    };

endpackage

// File: rtl/draw_bg_sprite_logo_mover.sv
// Bounces the logo origin inside the visible area, one step per frame tick.
module logo_mover
    import draw_bg_sprite_pkg::*;
#(
    parameter int HV_W    = 11,
    parameter int VIS_W   = 800,
    parameter int VIS_H   = 600,
    parameter int LOGO_W  = LOGO_W_DEF,
    parameter int LOGO_H  = LOGO_H_DEF,
    parameter int START_X = 394,
    parameter int START_Y = 300,
    parameter int STEP    = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_tick,
    input  logic          bounce_en,
    output logic [HV_W:0] pos_x,
    output logic [HV_W:0] pos_y
);

    localparam int PW = HV_W + 1;
    localparam logic [PW-1:0] STEP_P = PW'(STEP);
    localparam logic [PW-1:0] LIM_X  = PW'(VIS_W - LOGO_W);
    localparam logic [PW-1:0] LIM_Y  = PW'(VIS_H - LOGO_H);

    dir_e dir_x;
    dir_e dir_y;
    logic [PW:0] nx;
    logic [PW:0] ny;

    // Returns {new_dir, new_pos}; pos + STEP > lim is the same test as pos+STEP+LOGO > VIS.
    function automatic logic [PW:0] step_axis(input logic [PW-1:0] pos, input logic inc,
                                              input logic [PW-1:0] lim);
        logic [PW:0] r;
        if (inc && (pos + STEP_P > lim))
            r = {1'b0, lim};
        else if (!inc && (pos < STEP_P))
            r = {1'b1, {PW{1'b0}}};
        else if (inc)
            r = {1'b1, pos + STEP_P};
        else
            r = {1'b0, pos - STEP_P};
        return r;
    endfunction

    always_comb begin
        nx = step_axis(pos_x, dir_x == DIR_INC, LIM_X);
        ny = step_axis(pos_y, dir_y == DIR_INC, LIM_Y);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_x <= PW'(START_X);
            pos_y <= PW'(START_Y);
            dir_x <= DIR_INC;
            dir_y <= DIR_INC;
        end else if (frame_tick && bounce_en) begin
            pos_x <= nx[PW-1:0];
            dir_x <= dir_e'(nx[PW]);
            pos_y <= ny[PW-1:0];
            dir_y <= dir_e'(ny[PW]);
        end
    end

endmodule

// File: rtl/draw_bg_sprite.sv
// Background drawer: mode fill, coloured frame edges and a bouncing 1-bit logo,
// with all timing signals delayed by a fixed two-cycle pipeline.
module draw_bg_sprite
    import draw_bg_sprite_pkg::*;
#(
    parameter int          HV_W     = 11,
    parameter int          VIS_W    = 800,
    parameter int          VIS_H    = 600,
    parameter int          BORDER_T = 1,
    parameter int          LOGO_W   = LOGO_W_DEF,
    parameter int          LOGO_H   = LOGO_H_DEF,
    parameter int          START_X  = 394,
    parameter int          START_Y  = 300,
    parameter int          STEP     = 1,
    parameter logic [11:0] BG_RGB   = 12'h888,
    parameter logic [11:0] LOGO_RGB = 12'hfff
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [HV_W-1:0] vcount_in,
    input  logic            vsync_in,
    input  logic            vblnk_in,
    input  logic [HV_W-1:0] hcount_in,
    input  logic            hsync_in,
    input  logic            hblnk_in,
    input  logic [1:0]      mode_in,
    input  logic            bounce_en,
    output logic [HV_W-1:0] vcount_out,
    output logic            vsync_out,
    output logic            vblnk_out,
    output logic [HV_W-1:0] hcount_out,
    output logic            hsync_out,
    output logic            hblnk_out,
    output logic [11:0]     rgb_out
);

    localparam int PW = HV_W + 1;
    localparam int XW = (LOGO_W > 1) ? $clog2(LOGO_W) : 1;
    localparam int YW = (LOGO_H > 1) ? $clog2(LOGO_H) : 1;
    localparam logic [HV_W-1:0] BT    = HV_W'(BORDER_T);
    localparam logic [HV_W-1:0] BOT_Y = HV_W'(VIS_H - BORDER_T);
    localparam logic [HV_W-1:0] RGT_X = HV_W'(VIS_W - BORDER_T);
    localparam logic [PW-1:0]   LW_P  = PW'(LOGO_W);
    localparam logic [PW-1:0]   LH_P  = PW'(LOGO_H);

    function automatic edge_e edge_class(input logic [HV_W-1:0] h, input logic [HV_W-1:0] v);
        if (v < BT)          return EDGE_TOP;
        else if (v >= BOT_Y) return EDGE_BOTTOM;
        else if (h < BT)     return EDGE_LEFT;
        else if (h >= RGT_X) return EDGE_RIGHT;
        else                 return EDGE_NONE;
    endfunction

    function automatic logic [11:0] fill_colour(input logic [1:0] mode,
                                                input logic [HV_W-1:0] h,
                                                input logic [HV_W-1:0] v);
        case (mode_e'(mode))
            MODE_CHECKER:  return (h[3] ^ v[3]) ? RGB_CHECK_DARK : BG_RGB;
            MODE_GRADIENT: return {v[9:6], v[9:6], v[9:6]};
            default:       return BG_RGB;
        endcase
    endfunction

    logic          vblnk_prev;
    logic          tick_arm;
    logic          frame_tick;
    logic [PW-1:0] pos_x;
    logic [PW-1:0] pos_y;
    logic [PW-1:0] hx;
    logic [PW-1:0] vy;
    logic          in_logo;

    // tick_arm blocks a tick until vblnk has been seen low after reset.
    assign frame_tick = vblnk_in & ~vblnk_prev & tick_arm;
    assign hx = {1'b0, hcount_in};
    assign vy = {1'b0, vcount_in};
    assign in_logo = (hx >= pos_x) && (hx < pos_x + LW_P) &&
                     (vy >= pos_y) && (vy < pos_y + LH_P);

    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_prev <= 1'b0;
            tick_arm   <= 1'b0;
        end else begin
            vblnk_prev <= vblnk_in;
            if (!vblnk_in)
                tick_arm <= 1'b1;
        end
    end

    logo_mover #(
        .HV_W(HV_W), .VIS_W(VIS_W), .VIS_H(VIS_H), .LOGO_W(LOGO_W), .LOGO_H(LOGO_H),
        .START_X(START_X), .START_Y(START_Y), .STEP(STEP)
    ) u_mover (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .bounce_en(bounce_en),
        .pos_x(pos_x), .pos_y(pos_y)
    );

    logic [HV_W-1:0] hcount_p1, vcount_p1;
    logic            hsync_p1, hblnk_p1, vsync_p1, vblnk_p1;
    logic            blank_p1, in_logo_p1, hide_p1;
    edge_e           edge_p1;
    logic [XW-1:0]   rel_x_p1;
    logic [YW-1:0]   rel_y_p1;
    logic [11:0]     fill_p1;

    // Stage 1: classify the pixel and pick its fill colour.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_p1  <= '0;
            vcount_p1  <= '0;
            hsync_p1   <= 1'b0;
            hblnk_p1   <= 1'b0;
            vsync_p1   <= 1'b0;
            vblnk_p1   <= 1'b0;
            blank_p1   <= 1'b0;
            in_logo_p1 <= 1'b0;
            hide_p1    <= 1'b0;
            edge_p1    <= EDGE_NONE;
            rel_x_p1   <= '0;
            rel_y_p1   <= '0;
            fill_p1    <= '0;
        end else begin
            hcount_p1  <= hcount_in;
            vcount_p1  <= vcount_in;
            hsync_p1   <= hsync_in;
            hblnk_p1   <= hblnk_in;
            vsync_p1   <= vsync_in;
            vblnk_p1   <= vblnk_in;
            blank_p1   <= vblnk_in | hblnk_in;
            in_logo_p1 <= in_logo;
            hide_p1    <= (mode_e'(mode_in) == MODE_HIDDEN);
            edge_p1    <= edge_class(hcount_in, vcount_in);
            rel_x_p1   <= XW'(hx - pos_x);
            rel_y_p1   <= YW'(vy - pos_y);
            fill_p1    <= fill_colour(mode_in, hcount_in, vcount_in);
        end
    end

    // Stage 2: bitmap lookup and colour priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vsync_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hcount_out <= hcount_p1;
            vcount_out <= vcount_p1;
            hsync_out  <= hsync_p1;
            hblnk_out  <= hblnk_p1;
            vsync_out  <= vsync_p1;
            vblnk_out  <= vblnk_p1;
            if (blank_p1)
                rgb_out <= RGB_BLANK;
            else begin
                case (edge_p1)
                    EDGE_TOP:    rgb_out <= RGB_TOP;
                    EDGE_BOTTOM: rgb_out <= RGB_BOTTOM;
                    EDGE_LEFT:   rgb_out <= RGB_LEFT;
                    EDGE_RIGHT:  rgb_out <= RGB_RIGHT;
                    default:     rgb_out <= (in_logo_p1 && !hide_p1 && LOGO_ROM[rel_y_p1][rel_x_p1])
                                            ? LOGO_RGB : fill_p1;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_draw_bg_sprite.sv
// Scoreboard bench: two drawers (logo starting mid-screen and near the right edge)
// share one stimulus stream; a behavioural model predicts every output pixel.
module tb_draw_bg_sprite;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hcount, vcount;
    logic        hsync, hblnk, vsync, vblnk, bounce_en;
    logic [1:0]  mode;

    logic [10:0] hcount_a, vcount_a, hcount_b, vcount_b;
    logic        hsync_a, hblnk_a, vsync_a, vblnk_a;
    logic        hsync_b, hblnk_b, vsync_b, vblnk_b;
    logic [11:0] rgb_a, rgb_b;

    typedef struct {
        int h; int v; bit hb; bit vb; bit hs; bit vs; int md;
    } px_t;

    typedef struct {
        logic [10:0] h; logic [10:0] v;
        logic hs; logic hb; logic vs; logic vb;
        logic [11:0] rgb_a; logic [11:0] rgb_b;
    } exp_t;

    localparam logic [15:0] ROM [8] = '{16'hFFFF, 16'h8001, 16'hB3CD, 16'hA521,
                                        16'hA5A1, 16'hB3CD, 16'h8001, 16'hFFFF};

    px_t  stim[$];
    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   ax, ay, bx, by;
    bit   adx, ady, bdx, bdy, m_prev, m_arm;

    always #5 clk = ~clk;

    draw_bg_sprite dut_a (
        .clk(clk), .rst(rst),
        .vcount_in(vcount), .vsync_in(vsync), .vblnk_in(vblnk),
        .hcount_in(hcount), .hsync_in(hsync), .hblnk_in(hblnk),
        .mode_in(mode), .bounce_en(bounce_en),
        .vcount_out(vcount_a), .vsync_out(vsync_a), .vblnk_out(vblnk_a),
        .hcount_out(hcount_a), .hsync_out(hsync_a), .hblnk_out(hblnk_a),
        .rgb_out(rgb_a)
    );

    draw_bg_sprite #(.START_X(782)) dut_b (
        .clk(clk), .rst(rst),
        .vcount_in(vcount), .vsync_in(vsync), .vblnk_in(vblnk),
        .hcount_in(hcount), .hsync_in(hsync), .hblnk_in(hblnk),
        .mode_in(mode), .bounce_en(bounce_en),
        .vcount_out(vcount_b), .vsync_out(vsync_b), .vblnk_out(vblnk_b),
        .hcount_out(hcount_b), .hsync_out(hsync_b), .hblnk_out(hblnk_b),
        .rgb_out(rgb_b)
    );

    function automatic logic [11:0] model_rgb(int h, int v, bit blank, int md, int px, int py);
        logic [11:0] fill;
        logic [3:0]  g;
        logic [15:0] row;
        if (blank)    return 12'h000;
        if (v < 1)    return 12'hff0;
        if (v >= 599) return 12'hf00;
        if (h < 1)    return 12'h0f0;
        if (h >= 799) return 12'h00f;
        g = 4'((v >> 6) & 15);
        case (md)
            1:       fill = ((((h >> 3) ^ (v >> 3)) & 1) == 0) ? 12'h888 : 12'h444;
            2:       fill = {g, g, g};
            default: fill = 12'h888;
        endcase
        if (md != 3 && h >= px && h < px + 16 && v >= py && v < py + 8) begin
            row = ROM[v - py];
            if (row[h - px]) return 12'hfff;
        end
        return fill;
    endfunction

    task automatic mstep(inout int p, inout bit d, input int lim);
        if (d && p + 1 > lim) begin p = lim; d = 1'b0; end
        else if (!d && p < 1) begin p = 0; d = 1'b1; end
        else p = d ? p + 1 : p - 1;
    endtask

    task automatic reset_model();
        ax = 394; ay = 300; bx = 782; by = 300;
        adx = 1; ady = 1; bdx = 1; bdy = 1;
        m_prev = 0; m_arm = 0;
        sb.delete();
    endtask

    task automatic add_px(int h, int v, bit hb, bit vb, int md);
        px_t p;
        p.h = h; p.v = v; p.hb = hb; p.vb = vb; p.md = md;
        p.hs = 1'($urandom_range(0, 1)); p.vs = 1'($urandom_range(0, 1));
        stim.push_back(p);
    endtask

    task automatic add_frame(int md);
        add_px(810, 599, 1, 0, md);
        for (int i = 0; i < 3; i++) add_px(0, 600 + i, 1, 1, md);
        add_px(810, 0, 1, 0, md);
    endtask

    task automatic drive(input px_t p);
        exp_t e;
        bit   tick;
        hcount = 11'(p.h); vcount = 11'(p.v); hblnk = p.hb; vblnk = p.vb;
        hsync = p.hs; vsync = p.vs; mode = 2'(p.md);
        e.h = hcount; e.v = vcount; e.hs = p.hs; e.hb = p.hb; e.vs = p.vs; e.vb = p.vb;
        e.rgb_a = model_rgb(p.h, p.v, p.hb | p.vb, p.md, ax, ay);
        e.rgb_b = model_rgb(p.h, p.v, p.hb | p.vb, p.md, bx, by);
        sb.push_back(e);
        tick = p.vb && !m_prev && m_arm;
        if (!p.vb) m_arm = 1;
        m_prev = p.vb;
        if (tick && bounce_en) begin
            mstep(ax, adx, 784); mstep(ay, ady, 592);
            mstep(bx, bdx, 784); mstep(by, bdy, 592);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1; hcount = 11'd123; vcount = 11'd45; hsync = 1; vsync = 1;
        hblnk = 0; vblnk = 0; mode = 2'd1; bounce_en = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++;
            if ({hcount_a, vcount_a, hsync_a, hblnk_a, vsync_a, vblnk_a, rgb_a,
                 hcount_b, vcount_b, hsync_b, hblnk_b, vsync_b, vblnk_b, rgb_b} !== '0) begin
                bad++;
                $display("FAIL reset cyc=%0d rgb_a=%h rgb_b=%h hcount_a=%0d want all zero",
                         i, rgb_a, rgb_b, hcount_a);
            end
        end
        reset_model();
        rst = 0;
    endtask

    task automatic test_mode0();
        exp_t e;
        stim.delete();
        add_px(0, 0, 0, 0, 0);   add_px(0, 599, 0, 0, 0); add_px(0, 300, 0, 0, 0);
        add_px(799, 300, 0, 0, 0); add_px(100, 100, 0, 0, 0);
        add_px(900, 100, 1, 0, 0); add_px(100, 620, 0, 1, 0); add_px(500, 200, 1, 0, 0);
        for (int i = 0; i < 20; i++) add_px($urandom_range(0, 799), $urandom_range(0, 599), 0, 0, 0);
        add_px(810, 0, 1, 0, 0); add_px(810, 0, 1, 0, 0);
        foreach (stim[i]) begin
            drive(stim[i]);
            if (sb.size() >= 2) begin
                e = sb.pop_front();
                total++;
                if ({hcount_a, vcount_a, hsync_a, hblnk_a, vsync_a, vblnk_a} !== {e.h, e.v, e.hs, e.hb, e.vs, e.vb} ||
                    {hcount_b, vcount_b, hsync_b, hblnk_b, vsync_b, vblnk_b} !== {e.h, e.v, e.hs, e.hb, e.vs, e.vb}) begin
                    bad++;
                    $display("FAIL mode0_timing got h=%0d v=%0d want h=%0d v=%0d", hcount_a, vcount_a, e.h, e.v);
                end
                total++;
                if (rgb_a !== e.rgb_a) begin bad++; $display("FAIL mode0_rgb_a (%0d,%0d) got %h want %h", e.h, e.v, rgb_a, e.rgb_a); end
                total++;
                if (rgb_b !== e.rgb_b) begin bad++; $display("FAIL mode0_rgb_b (%0d,%0d) got %h want %h", e.h, e.v, rgb_b, e.rgb_b); end
            end
        end
    endtask

    task automatic test_modes();
        exp_t e;
        stim.delete();
        for (int h = 1; h < 16; h++) add_px(h, 10, 0, 0, 1);
        add_px(100, 64, 0, 0, 2); add_px(100, 128, 0, 0, 2); add_px(100, 63, 0, 0, 2); add_px(300, 599, 0, 0, 2);
        for (int h = 394; h < 410; h++) add_px(h, 300 + (h & 7), 0, 0, 3);
        add_px(394, 300, 0, 0, 0); add_px(394, 300, 0, 0, 3);
        add_px(810, 0, 1, 0, 0); add_px(810, 0, 1, 0, 0);
        foreach (stim[i]) begin
            drive(stim[i]);
            if (sb.size() >= 2) begin
                e = sb.pop_front();
                total++;
                if ({hcount_a, vcount_a, hsync_a, hblnk_a, vsync_a, vblnk_a} !== {e.h, e.v, e.hs, e.hb, e.vs, e.vb}) begin
                    bad++;
                    $display("FAIL modes_timing got h=%0d v=%0d want h=%0d v=%0d", hcount_a, vcount_a, e.h, e.v);
                end
                total++;
                if (rgb_a !== e.rgb_a) begin bad++; $display("FAIL modes_rgb_a (%0d,%0d) got %h want %h", e.h, e.v, rgb_a, e.rgb_a); end
                total++;
                if (rgb_b !== e.rgb_b) begin bad++; $display("FAIL modes_rgb_b (%0d,%0d) got %h want %h", e.h, e.v, rgb_b, e.rgb_b); end
            end
        end
    endtask

    task automatic test_hold();
        exp_t e;
        bounce_en = 0;
        stim.delete();
        for (int f = 0; f < 3; f++) add_frame(0);
        add_px(394, 300, 0, 0, 0); add_px(393, 300, 0, 0, 0); add_px(395, 301, 0, 0, 0);
        add_px(409, 300, 0, 0, 0); add_px(410, 300, 0, 0, 0); add_px(396, 302, 0, 0, 0);
        add_px(782, 300, 0, 0, 0); add_px(781, 300, 0, 0, 0);
        add_px(810, 0, 1, 0, 0); add_px(810, 0, 1, 0, 0);
        foreach (stim[i]) begin
            drive(stim[i]);
            if (sb.size() >= 2) begin
                e = sb.pop_front();
                total++;
                if ({hcount_a, vcount_a, hsync_a, hblnk_a, vsync_a, vblnk_a} !== {e.h, e.v, e.hs, e.hb, e.vs, e.vb}) begin
                    bad++;
                    $display("FAIL hold_timing got h=%0d v=%0d want h=%0d v=%0d", hcount_a, vcount_a, e.h, e.v);
                end
                total++;
                if (rgb_a !== e.rgb_a) begin bad++; $display("FAIL hold_rgb_a (%0d,%0d) got %h want %h", e.h, e.v, rgb_a, e.rgb_a); end
                total++;
                if (rgb_b !== e.rgb_b) begin bad++; $display("FAIL hold_rgb_b (%0d,%0d) got %h want %h", e.h, e.v, rgb_b, e.rgb_b); end
            end
        end
    endtask

    task automatic test_bounce();
        exp_t e;
        int xs[4] = '{783, 784, 784, 783};
        bounce_en = 1;
        stim.delete();
        for (int f = 0; f < 4; f++) begin
            add_frame(0);
            add_px(xs[f], 301 + f, 0, 0, 0);
            add_px(xs[f] - 1, 301 + f, 0, 0, 0);
            add_px(xs[f] + 15, 301 + f, 0, 0, 0);
            add_px(395 + f, 301 + f, 0, 0, 0);
        end
        add_px(810, 0, 1, 0, 0); add_px(810, 0, 1, 0, 0);
        foreach (stim[i]) begin
            drive(stim[i]);
            if (sb.size() >= 2) begin
                e = sb.pop_front();
                total++;
                if ({hcount_b, vcount_b, hsync_b, hblnk_b, vsync_b, vblnk_b} !== {e.h, e.v, e.hs, e.hb, e.vs, e.vb}) begin
                    bad++;
                    $display("FAIL bounce_timing got h=%0d v=%0d want h=%0d v=%0d", hcount_b, vcount_b, e.h, e.v);
                end
                total++;
                if (rgb_a !== e.rgb_a) begin bad++; $display("FAIL bounce_rgb_a (%0d,%0d) got %h want %h", e.h, e.v, rgb_a, e.rgb_a); end
                total++;
                if (rgb_b !== e.rgb_b) begin bad++; $display("FAIL bounce_rgb_b (%0d,%0d) got %h want %h", e.h, e.v, rgb_b, e.rgb_b); end
            end
        end
    endtask

    task automatic test_reset_midframe();
        exp_t e;
        bounce_en = 1;
        rst = 1; vblnk = 1; hblnk = 0; hcount = 11'd400; vcount = 11'd601; mode = 2'd0;
        @(posedge clk); #1;
        total++;
        if ({rgb_a, rgb_b, hcount_a, vcount_a, vblnk_a, vblnk_b} !== '0) begin
            bad++;
            $display("FAIL midframe_reset rgb_a=%h rgb_b=%h vblnk_a=%b want zero", rgb_a, rgb_b, vblnk_a);
        end
        reset_model();
        rst = 0;
        stim.delete();
        for (int i = 0; i < 3; i++) add_px(0, 602 + i, 1, 1, 0);
        add_px(810, 0, 1, 0, 0);
        add_px(394, 300, 0, 0, 0); add_px(395, 301, 0, 0, 0); add_px(782, 300, 0, 0, 0); add_px(783, 300, 0, 0, 0);
        add_frame(0);
        add_px(395, 301, 0, 0, 0); add_px(394, 301, 0, 0, 0); add_px(783, 301, 0, 0, 0); add_px(782, 301, 0, 0, 0);
        add_px(810, 0, 1, 0, 0); add_px(810, 0, 1, 0, 0);
        foreach (stim[i]) begin
            drive(stim[i]);
            if (sb.size() >= 2) begin
                e = sb.pop_front();
                total++;
                if ({hcount_a, vcount_a, hsync_a, hblnk_a, vsync_a, vblnk_a} !== {e.h, e.v, e.hs, e.hb, e.vs, e.vb}) begin
                    bad++;
                    $display("FAIL midframe_timing got h=%0d v=%0d want h=%0d v=%0d", hcount_a, vcount_a, e.h, e.v);
                end
                total++;
                if (rgb_a !== e.rgb_a) begin bad++; $display("FAIL midframe_rgb_a (%0d,%0d) got %h want %h", e.h, e.v, rgb_a, e.rgb_a); end
                total++;
                if (rgb_b !== e.rgb_b) begin bad++; $display("FAIL midframe_rgb_b (%0d,%0d) got %h want %h", e.h, e.v, rgb_b, e.rgb_b); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_modes();
        test_hold();
        test_bounce();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
